// File: rtl/frame_stream_pkg.sv
// frame_stream_pkg: state encoding, counter sizing helper and default geometry for the frame streamer.
package frame_stream_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, VSYNC = 3'd1, HSYNC = 3'd2, DATA = 3'd3, DRAIN = 3'd4} state_e;
  function automatic int clog2_min1(input int v);
    return v < 2 ? 1 : $clog2(v);
  endfunction
  localparam int DEF_WIDTH = 768;
  localparam int DEF_HEIGHT = 512;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_PPC = 2;
  localparam int BEATS = DEF_WIDTH / DEF_PPC;
  localparam int BEAT_W = DEF_PPC * DEF_CHANNELS * DEF_DATA_WIDTH;
  localparam int DEF_ADDR_W = clog2_min1(DEF_WIDTH * DEF_HEIGHT / DEF_PPC);
endpackage

// File: rtl/frame_pixel_streamer_if.sv
// frame_pixel_streamer_if: frame memory read port plus the outgoing valid/ready pixel stream.
interface frame_pixel_streamer_if import frame_stream_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BEAT_W = frame_stream_pkg::BEAT_W
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [BEAT_W-1:0] mem_rdata;
  logic [BEAT_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_eol;
  modport master (output mem_rd_en, mem_addr, pix_data, pix_valid, pix_eol, input mem_rdata, pix_ready);
  modport slave (input mem_rd_en, mem_addr, pix_data, pix_valid, pix_eol, output mem_rdata, pix_ready);
endinterface

// File: rtl/pixel_skid_fifo.sv
// pixel_skid_fifo: two-entry FIFO that catches read data returning while the consumer stalls.
module pixel_skid_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic [1:0]       count
);
  logic [WIDTH-1:0] mem_q [2];
  logic             wp_q, rp_q, pop;
  logic [1:0]       count_q;
  assign rd_valid = count_q != 2'd0;
  assign pop = rd_valid && rd_ready;
  assign rd_data = rd_valid ? mem_q[rp_q] : '0;
  assign count = count_q;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (wr_en) begin
        mem_q[wp_q] <= wr_data;
        wp_q <= ~wp_q;
      end
      if (pop) rp_q <= ~rp_q;
      count_q <= count_q + {1'b0, wr_en} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer: streams a stored frame row by row with sync blanking and valid/ready backpressure.
module frame_pixel_streamer import frame_stream_pkg::*; #(
  parameter int IMAGE_WIDTH  = DEF_WIDTH,
  parameter int IMAGE_HEIGHT = DEF_HEIGHT,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CHANNELS     = DEF_CHANNELS,
  parameter int PIX_PER_CLK  = DEF_PPC,
  parameter int START_DELAY  = 100,
  parameter int HSYNC_DELAY  = 160,
  parameter int BOTTOM_UP    = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  frame_pixel_streamer_if.master bus,
  output logic vertical_Pulse,
  output logic horizontal_Pulse,
  output logic busy,
  output logic sig_done
);
  localparam int NB = IMAGE_WIDTH / PIX_PER_CLK;
  localparam int BW = PIX_PER_CLK * CHANNELS * DATA_WIDTH;
  localparam int ADDR_W = clog2_min1(IMAGE_WIDTH * IMAGE_HEIGHT / PIX_PER_CLK);
  localparam int CNT_W = clog2_min1(START_DELAY > HSYNC_DELAY ? START_DELAY : HSYNC_DELAY);
  localparam int ROW_W = clog2_min1(IMAGE_HEIGHT);
  localparam int COL_W = clog2_min1(NB);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ROW_W-1:0] row_q, row_d, mrow;
  logic [COL_W-1:0] beat_q, beat_d;
  logic             inflight_q, eol_q, rd, last_beat, last_row;
  logic [1:0]       fcount;
  logic [BW:0]      fifo_out;
  assign last_beat = beat_q == COL_W'(NB - 1);
  assign last_row = row_q == ROW_W'(IMAGE_HEIGHT - 1);
  assign mrow = BOTTOM_UP != 0 ? ROW_W'(IMAGE_HEIGHT - 1) - row_q : row_q;
  // Words in the FIFO plus the word still returning from memory may never exceed the two FIFO slots.
  assign rd = state_q == DATA && ({1'b0, fcount} + {2'b0, inflight_q} < 3'd2);
  assign vertical_Pulse = state_q == VSYNC;
  assign horizontal_Pulse = state_q == HSYNC;
  assign busy = state_q != IDLE;
  assign bus.mem_rd_en = rd;
  assign bus.mem_addr = rd ? ADDR_W'(mrow * NB + beat_q) : '0;
  assign bus.pix_data = fifo_out[BW-1:0];
  assign bus.pix_eol = fifo_out[BW];
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      row_q <= '0;
      beat_q <= '0;
      inflight_q <= 1'b0;
      eol_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      beat_q <= beat_d;
      inflight_q <= rd;
      eol_q <= last_beat;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    row_d = row_q;
    beat_d = beat_q;
    sig_done = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = VSYNC;
        cnt_d = '0;
        row_d = '0;
        beat_d = '0;
      end
      VSYNC: begin
        cnt_d = cnt_q == CNT_W'(START_DELAY - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(START_DELAY - 1) ? HSYNC : VSYNC;
      end
      HSYNC: begin
        cnt_d = cnt_q == CNT_W'(HSYNC_DELAY - 1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(HSYNC_DELAY - 1) ? DATA : HSYNC;
      end
      DATA: if (rd) begin
        beat_d = last_beat ? '0 : beat_q + 1'b1;
        row_d = last_beat && !last_row ? row_q + 1'b1 : row_q;
        state_d = !last_beat ? DATA : last_row ? DRAIN : HSYNC;
      end
      DRAIN: if (fcount == 2'd0 && !inflight_q) begin
        sig_done = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  pixel_skid_fifo #(.WIDTH(BW + 1)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (inflight_q),
    .wr_data  ({eol_q, bus.mem_rdata}),
    .rd_ready (bus.pix_ready),
    .rd_valid (bus.pix_valid),
    .rd_data  (fifo_out),
    .count    (fcount)
  );
endmodule

// File: tb/tb_frame_pixel_streamer.sv
// tb_frame_pixel_streamer: three small configurations streamed against a row/beat reference model.
`define RST_CHECKS(K) \
  check($sformatf("rst_ctl_%0d", K), 64'({g_i[K].bus.mem_rd_en, g_i[K].bus.pix_valid, g_i[K].bus.pix_eol, vp[K], hp[K], busy[K], done[K]}), 64'(0)); \
  check($sformatf("rst_data_%0d", K), 64'(g_i[K].bus.pix_data), 64'(0)); \
  check($sformatf("rst_addr_%0d", K), 64'(g_i[K].bus.mem_addr), 64'(0));
`define FRAME_CHECKS(K, NF) \
  check($sformatf("beats_%0d", K), 64'(g_i[K].n), 64'((NF) * tot(K))); \
  check($sformatf("data_%0d", K), 64'(g_i[K].bad), 64'(0)); \
  check($sformatf("done_cnt_%0d", K), 64'(g_i[K].ndone), 64'(NF)); \
  check($sformatf("done_pos_%0d", K), 64'(g_i[K].done_bad), 64'(0)); \
  check($sformatf("vsync_%0d", K), 64'(g_i[K].vcyc), 64'(3 * (NF))); \
  check($sformatf("hsync_%0d", K), 64'(g_i[K].hcyc), 64'(2 * H * (NF))); \
  check($sformatf("eol_%0d", K), 64'(g_i[K].neol), 64'(H * (NF))); \
  check($sformatf("first_addr_%0d", K), 64'(g_i[K].first_addr), 64'(first_a(K))); \
  check($sformatf("latency_%0d", K), 64'(g_i[K].first_vld - g_i[K].first_rd), 64'(2)); \
  check($sformatf("outstanding_%0d", K), 64'(g_i[K].ovf), 64'(0)); \
  check($sformatf("stall_hold_%0d", K), 64'(g_i[K].stall_bad), 64'(0));
module tb_frame_pixel_streamer;
  localparam int W = 8;
  localparam int H = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] start = '0;
  logic [2:0] ready = '1;
  logic [2:0] vp, hp, busy, done;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int tot(input int k);
    return k == 2 ? 32 : 16;
  endfunction
  function automatic int first_a(input int k);
    return k == 1 ? 0 : k == 2 ? 24 : 12;
  endfunction
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  for (genvar g = 0; g < 3; g++) begin : g_i
    localparam int PPC = g == 2 ? 1 : 2;
    localparam int CH = g == 2 ? 1 : 3;
    localparam int BU = g == 1 ? 0 : 1;
    localparam int NB = W / PPC;
    localparam int TOT = NB * H;
    localparam int BW = PPC * CH * 8;
    localparam int AW = $clog2(TOT);
    logic [BW-1:0] mem [TOT];
    logic [BW-1:0] held;
    logic was_stalled;
    int n, ndone, done_bad, vcyc, hcyc, neol, bad, stall_bad, ovf, issued, first_rd, first_vld, first_addr;
    frame_pixel_streamer_if #(.ADDR_W(AW), .BEAT_W(BW)) bus ();
    frame_pixel_streamer #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .DATA_WIDTH(8), .CHANNELS(CH), .PIX_PER_CLK(PPC),
      .START_DELAY(3), .HSYNC_DELAY(2), .BOTTOM_UP(BU)
    ) dut (
      .clk(clk), .reset(reset), .start(start[g]), .bus(bus),
      .vertical_Pulse(vp[g]), .horizontal_Pulse(hp[g]), .busy(busy[g]), .sig_done(done[g])
    );
    // Random upper bits with the address in the low bits keep every word unique.
    initial for (int a = 0; a < TOT; a++) mem[a] = (BW'({$urandom, $urandom}) << AW) | BW'(a);
    assign bus.pix_ready = ready[g];
    always @(posedge clk) bus.mem_rdata <= bus.mem_rd_en ? mem[bus.mem_addr] : BW'({$urandom, $urandom});
    function automatic logic [BW:0] model(input int i);
      int k, r, b;
      k = i % TOT;
      r = k / NB;
      b = k % NB;
      r = BU != 0 ? H - 1 - r : r;
      return {b == NB - 1, mem[AW'(r * NB + b)]};
    endfunction
    always @(posedge clk) begin
      if (!reset) begin
        n <= 0; ndone <= 0; done_bad <= 0; vcyc <= 0; hcyc <= 0; neol <= 0; bad <= 0;
        stall_bad <= 0; ovf <= 0; issued <= 0; first_rd <= -1; first_vld <= -1; first_addr <= -1;
        was_stalled <= 1'b0;
      end else begin
        if (bus.pix_valid && bus.pix_ready) begin
          n <= n + 1;
          neol <= neol + int'(bus.pix_eol);
          if ({bus.pix_eol, bus.pix_data} !== model(n)) bad <= bad + 1;
        end
        if (bus.mem_rd_en) begin
          issued <= issued + 1;
          if (first_rd < 0) begin
            first_rd <= cyc;
            first_addr <= int'(bus.mem_addr);
          end
        end
        if (bus.pix_valid && first_vld < 0) first_vld <= cyc;
        if (issued - n > 2) ovf <= ovf + 1;
        if (was_stalled && (!bus.pix_valid || bus.pix_data !== held)) stall_bad <= stall_bad + 1;
        was_stalled <= bus.pix_valid && !bus.pix_ready;
        held <= bus.pix_data;
        if (done[g]) begin
          ndone <= ndone + 1;
          if (n == 0 || n % TOT != 0) done_bad <= done_bad + 1;
        end
        vcyc <= vcyc + int'(vp[g]);
        hcyc <= hcyc + int'(hp[g]);
      end
    end
  end
  initial begin
    int t, hold;
    bit did;
    logic [2:0] pend;
    repeat (3) @(negedge clk);
    `RST_CHECKS(0)
    `RST_CHECKS(1)
    `RST_CHECKS(2)
    reset = 1'b1;
    @(negedge clk);
    start = '1;
    t = 0;
    while ((g_i[0].ndone < 1 || g_i[1].ndone < 1 || g_i[2].ndone < 1) && t < 2000) begin
      @(negedge clk);
      t++;
      start = (t == 10 || t == 20) ? 3'b111 : 3'b000;
    end
    check("timeout_single", 64'(t < 2000), 64'(1));
    `FRAME_CHECKS(0, 1)
    `FRAME_CHECKS(1, 1)
    `FRAME_CHECKS(2, 1)
    start = '1;
    pend = '0;
    hold = 0;
    did = 1'b0;
    t = 0;
    while ((g_i[0].ndone < 3 || g_i[1].ndone < 3 || g_i[2].ndone < 3) && t < 4000) begin
      @(negedge clk);
      t++;
      start = pend | (busy & 3'($urandom_range(0, 7)) & {3{$urandom_range(0, 9) == 0}});
      pend = done & {g_i[2].ndone < 2, g_i[1].ndone < 2, g_i[0].ndone < 2};
      ready = 3'($urandom);
      if (!did && g_i[0].n >= 21) begin
        did = 1'b1;
        hold = 5;
      end
      if (hold > 0) begin
        ready[0] = 1'b0;
        if (hold == 1) check("stall_outstanding", 64'(g_i[0].issued - g_i[0].n), 64'(2));
        hold--;
      end
    end
    check("timeout_b2b", 64'(t < 4000), 64'(1));
    `FRAME_CHECKS(0, 3)
    `FRAME_CHECKS(1, 3)
    `FRAME_CHECKS(2, 3)
    start = '0;
    ready = '1;
    @(negedge clk);
    start = '1;
    @(negedge clk);
    start = '0;
    t = 0;
    while (g_i[0].n < 3 * 16 + 9 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("timeout_midframe", 64'(t < 1000), 64'(1));
    reset = 1'b0;
    @(negedge clk);
    `RST_CHECKS(0)
    `RST_CHECKS(1)
    `RST_CHECKS(2)
    reset = 1'b1;
    @(negedge clk);
    start = '1;
    @(negedge clk);
    start = '0;
    t = 0;
    while ((g_i[0].ndone < 1 || g_i[1].ndone < 1 || g_i[2].ndone < 1) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("timeout_restart", 64'(t < 2000), 64'(1));
    `FRAME_CHECKS(0, 1)
    `FRAME_CHECKS(1, 1)
    `FRAME_CHECKS(2, 1)
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
Parametrised, synthesizable frame source for the threshold/filter pipeline. Fetches a stored RGB frame from an external frame memory and streams it row by row, PIX_PER_CLK pixels per beat. Emits vertical and horizontal blanking intervals, handles downstream backpressure with valid/ready, and flags completion. It replaces the simulation-only loader and sits between frame memory and the pixel-processing stages.

Parameters:
IMAGE_WIDTH, 768, pixels per row; must be a multiple of PIX_PER_CLK.
IMAGE_HEIGHT, 512, rows per frame.
DATA_WIDTH, 8, bits per colour channel.
CHANNELS, 3, channels per pixel; channel 0 sits in the LSBs of each pixel.
PIX_PER_CLK, 2, pixels per beat; pixel 0 (even column) sits in the LSBs.
START_DELAY, 100, cycles vsync_pulse stays high before the first row.
HSYNC_DELAY, 160, cycles hsync_pulse stays high before each row.
BOTTOM_UP, 1, 1 = memory row 0 is the image bottom (BMP order), 0 = top-down.

Ports:
clk  in  1  sole clock, rising edge.
reset  in  1  synchronous, active-low reset.
start  in  1  one-cycle request to stream a frame; honoured only in IDLE.
mem_rd_en  out  1  frame memory read strobe.
mem_addr  out  ADDR_W  word address, ADDR_W = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT/PIX_PER_CLK).
mem_rdata  in  PIX_PER_CLK*CHANNELS*DATA_WIDTH  read word, valid exactly 1 cycle after mem_rd_en.
pix_data  out  PIX_PER_CLK*CHANNELS*DATA_WIDTH  output beat.
pix_valid  out  1  pix_data valid.
pix_ready  in  1  downstream accepts the beat when pix_valid && pix_ready.
pix_eol  out  1  beat is the last of its row; qualified by pix_valid.
vertical_Pulse  out  1  high during the start-of-frame blanking.
horizontal_Pulse  out  1  high during each row's blanking.
busy  out  1  high in every state except IDLE.
sig_done  out  1  one-cycle pulse when the last beat of the frame is accepted.

Behaviour:
- Reset (reset==0 at a clk edge) forces all outputs to 0 and the FSM to IDLE, clears counters, flushes the FIFO and discards any in-flight read. The reset takes effect on that edge even in mid-frame.
- States: IDLE, VSYNC, HSYNC, DATA, DRAIN.
- IDLE: start -> VSYNC. start is ignored in every other state.
- VSYNC: vertical_Pulse=1 for exactly START_DELAY cycles, then -> HSYNC.
- HSYNC: horizontal_Pulse=1 for exactly HSYNC_DELAY cycles, then -> DATA.
- DATA: issues BEATS = IMAGE_WIDTH/PIX_PER_CLK reads for the current row.
  - After the last read of a non-final row -> HSYNC.
  - After the last read of the final row -> DRAIN.
- DRAIN: when the FIFO is empty and no read is in flight, assert sig_done for one cycle and go to IDLE.
- Address: mem_addr = mrow*BEATS + beat.
  - mrow = IMAGE_HEIGHT-1-row when BOTTOM_UP=1, else mrow = row.
  - row and beat count up from 0.
- Flow control: a 2-entry FIFO holds returned words.
  - A read issues in DATA only when (FIFO occupancy + in-flight reads) < 2.
  - Consequence: no word is ever dropped, and at most 2 beats are outstanding.
- Timing: first pix_valid comes 2 cycles after the first mem_rd_en when pix_ready=1. That is 1 cycle of memory latency plus the FIFO register.
- pix_eol travels through the FIFO alongside its data word.
- While pix_ready=1 and the FIFO is non-empty, throughput is 1 beat/clk.
- Blanking and draining overlap: HSYNC/VSYNC counting continues while the FIFO drains.
- pix_data holds its value while pix_valid && !pix_ready.
- Counters are sized with $clog2 of their maximum value + 1; no counter wraps within a frame.
- Once sig_done has pulsed, a start in the next cycle begins a new frame. Back-to-back frames must work.

Decomposition:
- Shared package frame_stream_pkg:
  - state encoding (IDLE=0, VSYNC=1, HSYNC=2, DATA=3, DRAIN=4, 3 bits);
  - function clog2_min1;
  - derived localparams BEATS and BEAT_W (= PIX_PER_CLK*CHANNELS*DATA_WIDTH).
- One sub-module, pixel_skid_fifo: a 2-entry FIFO parametrised on width.
  - Ports: clk, reset, wr_en, wr_data, rd_ready, rd_valid, rd_data, count.

Test Plan:
1. Default-ordered small config (W=8, H=4, PPC=2, START_DELAY=3, HSYNC_DELAY=2, BOTTOM_UP=1); memory word = its address; pix_ready=1. Pulse start -> vertical_Pulse high 3 cycles, then horizontal_Pulse high 2 cycles. Addresses issued: 12,13,14,15, then 8..11, 4..7, 0..3. pix_eol set on beats carrying 15, 11, 7, 3. sig_done pulses once after beat 3 is accepted.
2. Same config with BOTTOM_UP=0 -> beats 0..15 in order; 16 beats total, no duplicates.
3. pix_ready held low for 5 cycles mid-row -> mem_rd_en stops after 2 outstanding. pix_data is stable while stalled. Sequence stays 12..15, 8.. with no loss or repeat.
4. PIX_PER_CLK=1, CHANNELS=1, W=8, H=4 -> 32 beats, 4 pix_eol, sig_done after beat 32.
5. reset driven low for one cycle during row 2 -> next cycle all outputs are 0 and busy=0. A following start restarts from address 12.
6. start re-pulsed while busy -> ignored, with exactly 16 beats delivered. start the cycle after sig_done -> second identical frame follows.
